// File: rtl/pcie_lane_pkg.sv
// ============================================================================
// pcie_lane_pkg : COM symbol and lane alignment state encoding (shared TX/RX)
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pcie_lane_pkg;

  localparam logic [7:0] COM_BYTE = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/pcie_rx_shift8.sv
// ============================================================================
// pcie_rx_shift8 : serial shift window with mod-8 bit counter and boundary flag
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pcie_rx_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [7:0] win,
  output logic       boundary
);

  // Only the seven most recent bits need storing; the eighth is the live input.
  logic [6:0] shift;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= 7'd0;
      bit_cnt <= 3'd0;
    end else if (en) begin
      shift   <= win[6:0];
      bit_cnt <= clr ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  assign win      = {shift, din};
  assign boundary = en && (bit_cnt == 3'd7);

endmodule

`default_nettype wire

// File: rtl/pcie_serial_byte_rx.sv
// ============================================================================
// pcie_serial_byte_rx : MSB-first serial-to-byte receiver with COM alignment.
// Build option PCIE_RX_COM_STRIP_EN: suppress delivery of COM bytes once locked.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module pcie_serial_byte_rx #(
  parameter logic [7:0] COM_BYTE    = pcie_lane_pkg::COM_BYTE,
  parameter int         LOCK_COMS   = 2,
  parameter int         COM_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       data_in,
  input  logic       bit_valid,
  output logic [7:0] DATA_OUT,
  output logic       VALID_OUT,
  output logic       ACTIVE,
  output logic       COM_DET
);

  import pcie_lane_pkg::*;

  localparam int CW = $clog2(LOCK_COMS + 1);
  localparam int GW = $clog2(COM_TIMEOUT + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COMS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(COM_TIMEOUT - 1);
`ifdef PCIE_RX_COM_STRIP_EN
  localparam bit DELIVER_COM = 1'b0;
`else
  localparam bit DELIVER_COM = 1'b1;
`endif

  lane_state_t   state;
  logic [CW-1:0] com_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    win;
  logic          boundary;
  logic          is_com;
  logic          search_hit;

  assign is_com     = (win == COM_BYTE);
  // Any-alignment match in SEARCH re-phases the byte counter to this bit.
  assign search_hit = bit_valid && (state == SEARCH) && is_com;

  pcie_rx_shift8 u_shift (
    .clk      (CLK),
    .rst      (RESET),
    .en       (bit_valid),
    .clr      (search_hit),
    .din      (data_in),
    .win      (win),
    .boundary (boundary)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= SEARCH;
      com_cnt   <= '0;
      gap_cnt   <= '0;
      DATA_OUT  <= 8'd0;
      VALID_OUT <= 1'b0;
      ACTIVE    <= 1'b0;
      COM_DET   <= 1'b0;
    end else begin
      VALID_OUT <= 1'b0;
      COM_DET   <= 1'b0;
      if (bit_valid) begin
        case (state)
          SEARCH: begin
            if (is_com) begin
              com_cnt <= CW'(1);
              COM_DET <= 1'b1;
              if (LOCK_COMS == 1) begin
                state   <= LOCKED;
                ACTIVE  <= 1'b1;
                gap_cnt <= '0;
                if (DELIVER_COM) begin
                  DATA_OUT  <= win;
                  VALID_OUT <= 1'b1;
                end
              end else begin
                state <= LOCKING;
              end
            end
          end
          LOCKING: begin
            if (boundary) begin
              if (is_com) begin
                COM_DET <= 1'b1;
                com_cnt <= com_cnt + 1'b1;
                // The COM completing the lock is the first byte delivered.
                if (com_cnt == LOCK_LAST) begin
                  state   <= LOCKED;
                  ACTIVE  <= 1'b1;
                  gap_cnt <= '0;
                  if (DELIVER_COM) begin
                    DATA_OUT  <= win;
                    VALID_OUT <= 1'b1;
                  end
                end
              end else begin
                com_cnt <= '0;
                state   <= SEARCH;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (is_com) begin
                COM_DET <= 1'b1;
                gap_cnt <= '0;
                if (DELIVER_COM) begin
                  DATA_OUT  <= win;
                  VALID_OUT <= 1'b1;
                end
              end else begin
                DATA_OUT  <= win;
                VALID_OUT <= 1'b1;
                if (gap_cnt == GAP_LAST) begin
                  state   <= SEARCH;
                  ACTIVE  <= 1'b0;
                  com_cnt <= '0;
                  gap_cnt <= '0;
                end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                end
              end
            end
          end
          default: begin
            state   <= SEARCH;
            com_cnt <= '0;
            ACTIVE  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcie_serial_byte_rx.sv
// ============================================================================
// tb_pcie_serial_byte_rx : directed self-checking bench for the serial byte receiver
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_pcie_serial_byte_rx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       data_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT;
  logic       ACTIVE;
  logic       COM_DET;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef PCIE_RX_COM_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  pcie_serial_byte_rx #(
    .LOCK_COMS   (2),
    .COM_TIMEOUT (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .ACTIVE    (ACTIVE),
    .COM_DET   (COM_DET)
  );

  always #5 CLK = ~CLK;

  // Status word: {VALID_OUT, DATA_OUT, COM_DET, ACTIVE, strobe seen before 8th bit}
  function automatic logic [11:0] exp_st(input logic v, input logic [7:0] d,
                                         input logic c, input logic a);
    return {v, d, c, a, 1'b0};
  endfunction

  task automatic tick(input logic d, input logic v);
    data_in   = d;
    bit_valid = v;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [11:0] st);
    logic mid;
    mid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick(b[i], 1'b1);
      if (i != 0 && (VALID_OUT !== 1'b0 || COM_DET !== 1'b0)) mid = 1'b1;
    end
    st = {VALID_OUT, DATA_OUT, COM_DET, ACTIVE, mid};
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      o = {VALID_OUT, DATA_OUT, COM_DET, ACTIVE};
      n_checks++;
      if (o !== 11'd0) begin
        n_fails++;
        $display("FAIL reset_outputs[%0d]: got %h required %h", i, o, 11'd0);
      end
    end
    RESET = 1'b0;
  endtask

  task automatic test_lock();
    logic [11:0] st, e;
    do_reset();
    send_byte(8'hBC, st);
    e = exp_st(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL lock_com1: got %h required %h", st, e); end
    send_byte(8'hBC, st);
    e = STRIP ? exp_st(1'b0, 8'h00, 1'b1, 1'b1) : exp_st(1'b1, 8'hBC, 1'b1, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL lock_com2: got %h required %h", st, e); end
    send_byte(8'h25, st);
    e = exp_st(1'b1, 8'h25, 1'b0, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL lock_data25: got %h required %h", st, e); end
  endtask

  task automatic test_misaligned();
    logic [11:0] st, e;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    send_byte(8'hBC, st);
    e = exp_st(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL mis_com1: got %h required %h", st, e); end
    send_byte(8'hBC, st);
    e = STRIP ? exp_st(1'b0, 8'h00, 1'b1, 1'b1) : exp_st(1'b1, 8'hBC, 1'b1, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL mis_com2: got %h required %h", st, e); end
    send_byte(8'hF9, st);
    e = exp_st(1'b1, 8'hF9, 1'b0, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL mis_dataF9: got %h required %h", st, e); end
    send_byte(8'h4F, st);
    e = exp_st(1'b1, 8'h4F, 1'b0, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL mis_data4F: got %h required %h", st, e); end
  endtask

  task automatic test_gaps();
    logic [11:0] st;
    logic [8:0]  o, eo;
    logic [10:0] f, ef;
    logic [7:0]  b;
    do_reset();
    send_byte(8'hBC, st);
    send_byte(8'hBC, st);
    b = 8'hA6;
    for (int i = 7; i >= 4; i--) tick(b[i], 1'b1);
    eo = {1'b0, (STRIP ? 8'h00 : 8'hBC)};
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      o = {VALID_OUT, DATA_OUT};
      n_checks++;
      if (o !== eo) begin n_fails++; $display("FAIL gap_hold[%0d]: got %h required %h", i, o, eo); end
    end
    for (int i = 3; i >= 1; i--) tick(b[i], 1'b1);
    n_checks++;
    if (VALID_OUT !== 1'b0) begin
      n_fails++; $display("FAIL gap_early_valid: got %b required 0", VALID_OUT);
    end
    tick(b[0], 1'b1);
    f  = {VALID_OUT, DATA_OUT, COM_DET, ACTIVE};
    ef = {1'b1, 8'hA6, 1'b0, 1'b1};
    n_checks++;
    if (f !== ef) begin n_fails++; $display("FAIL gap_byteA6: got %h required %h", f, ef); end
    tick(1'b0, 1'b0);
    o  = {VALID_OUT, DATA_OUT};
    eo = {1'b0, 8'hA6};
    n_checks++;
    if (o !== eo) begin n_fails++; $display("FAIL gap_single_strobe: got %h required %h", o, eo); end
  endtask

  task automatic test_timeout();
    logic [11:0] st, e;
    do_reset();
    send_byte(8'hBC, st);
    send_byte(8'hBC, st);
    send_byte(8'h39, st);
    send_byte(8'hA8, st);
    send_byte(8'hF9, st);
    e = exp_st(1'b1, 8'hF9, 1'b0, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL timeout_third: got %h required %h", st, e); end
    send_byte(8'h4F, st);
    e = exp_st(1'b1, 8'h4F, 1'b0, 1'b0);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL timeout_drop: got %h required %h", st, e); end
    send_byte(8'hBC, st);
    e = exp_st(1'b0, 8'h4F, 1'b1, 1'b0);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL timeout_research: got %h required %h", st, e); end
    send_byte(8'hBC, st);
    e = STRIP ? exp_st(1'b0, 8'h4F, 1'b1, 1'b1) : exp_st(1'b1, 8'hBC, 1'b1, 1'b1);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL timeout_relock: got %h required %h", st, e); end
  endtask

  task automatic test_broken_lock();
    logic [11:0] st, e;
    logic [10:0] f;
    logic [7:0]  b;
    do_reset();
    send_byte(8'hBC, st);
    send_byte(8'h00, st);
    e = exp_st(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL broken_zero: got %h required %h", st, e); end
    send_byte(8'h25, st);
    n_checks++;
    if (st !== e) begin n_fails++; $display("FAIL broken_no_data: got %h required %h", st, e); end
    do_reset();
    send_byte(8'hBC, st);
    send_byte(8'hBC, st);
    b = 8'h39;
    for (int i = 7; i >= 4; i--) tick(b[i], 1'b1);
    n_checks++;
    if (ACTIVE !== 1'b1) begin n_fails++; $display("FAIL rst_pre_active: got %b required 1", ACTIVE); end
    RESET = 1'b1;
    tick(b[3], 1'b1);
    f = {VALID_OUT, DATA_OUT, COM_DET, ACTIVE};
    n_checks++;
    if (f !== 11'd0) begin n_fails++; $display("FAIL rst_midlock: got %h required %h", f, 11'd0); end
    RESET = 1'b0;
    // Remainder of the discarded byte must not produce output.
    for (int i = 2; i >= 0; i--) tick(b[i], 1'b1);
    f = {VALID_OUT, DATA_OUT, COM_DET, ACTIVE};
    n_checks++;
    if (f !== 11'd0) begin n_fails++; $display("FAIL rst_partial_discard: got %h required %h", f, 11'd0); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_misaligned();
    test_gaps();
    test_timeout();
    test_broken_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
